// File: rtl/lc3_writeback.sv
// lc3_writeback: write-side driver for the LC3 8x16 register file.
//
// Completed results arrive over wb_valid/wb_ready, the writeback source is
// picked by W_Control at enqueue, and entries sit in an in-order queue of
// DEPTH slots. One entry per cycle drains into the registered wr/dr/din
// register-file port. The block also owns the NZP condition codes and
// reports read-after-write hazards for the decode source registers.
//
// Ports:
//   clock, reset          clock; synchronous active-high reset
//   wb_valid / wb_ready   upstream handshake (ready = count < DEPTH)
//   W_Control             0 aluout, 1 memout, 2 pcout, 3 npc
//   aluout/memout/pcout/npc  candidate result values
//   dr_in, set_cc         destination register, update-NZP flag
//   hold                  freeze draining
//   sr1, sr2              decode sources for hazard checks
//   wr, dr, din           register-file write port (registered)
//   psr                   {N,Z,P} (registered)
//   hazard1, hazard2      source matches a queued destination (comb)
//   count                 occupied entries
//   fwd1_*/fwd2_*         youngest queued data per source (LC3_WB_BYPASS_EN)
//
// Optional feature macro: LC3_WB_BYPASS_EN

// Per-entry destination compare against both decode sources.
module lc3_wb_match (
  input  logic       vld,
  input  logic [2:0] dr,
  input  logic [2:0] sr1,
  input  logic [2:0] sr2,
  output logic       m1,
  output logic       m2
);
  assign m1 = vld && (dr == sr1);
  assign m2 = vld && (dr == sr2);
endmodule

module lc3_writeback #(
  parameter int DEPTH  = 2,
  parameter int DATA_W = 16
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     wb_valid,
  output logic                     wb_ready,
  input  logic [1:0]               W_Control,
  input  logic [DATA_W-1:0]        aluout,
  input  logic [DATA_W-1:0]        memout,
  input  logic [DATA_W-1:0]        pcout,
  input  logic [DATA_W-1:0]        npc,
  input  logic [2:0]               dr_in,
  input  logic                     set_cc,
  input  logic                     hold,
  input  logic [2:0]               sr1,
  input  logic [2:0]               sr2,
  output logic                     wr,
  output logic [2:0]               dr,
  output logic [DATA_W-1:0]        din,
  output logic [2:0]               psr,
  output logic                     hazard1,
  output logic                     hazard2,
`ifdef LC3_WB_BYPASS_EN
  output logic                     fwd1_valid,
  output logic [DATA_W-1:0]        fwd1_data,
  output logic                     fwd2_valid,
  output logic [DATA_W-1:0]        fwd2_data,
`endif
  output logic [$clog2(DEPTH):0]   count
);
  localparam int AW = $clog2(DEPTH);

  typedef struct packed {
    logic [2:0]        dr;
    logic              cc;
    logic [DATA_W-1:0] data;
  } wb_entry_t;

  wb_entry_t [DEPTH-1:0] q;
  logic [DEPTH-1:0]      q_vld;
  logic [AW-1:0]         wptr, rptr;
  logic [DATA_W-1:0]     wdata;
  logic                  push, pop;
  logic [DEPTH-1:0]      m1, m2;

  function automatic logic [2:0] nzp(input logic [DATA_W-1:0] d);
    if (d[DATA_W-1])  return 3'b100;
    else if (d == '0) return 3'b010;
    else              return 3'b001;
  endfunction

  // Source mux resolved at enqueue so later input changes cannot leak in.
  always_comb begin
    wdata = aluout;
    unique case (W_Control)
      2'd0: wdata = aluout;
      2'd1: wdata = memout;
      2'd2: wdata = pcout;
      2'd3: wdata = npc;
    endcase
  end

  // Ready depends only on registered count: no ready-from-drain path.
  assign wb_ready = (count < (AW+1)'(DEPTH));
  assign push     = wb_valid && wb_ready;
  // Only entries already resident can drain, so no same-edge fall-through.
  assign pop      = (count != '0) && !hold;

  // push and pop never address the same slot: push needs a free slot,
  // pop needs an occupied one, and they share an index only when empty/full.
  always_ff @(posedge clock) begin
    if (reset) begin
      q     <= '0;
      q_vld <= '0;
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
      wr    <= 1'b0;
      dr    <= '0;
      din   <= '0;
      psr   <= 3'b010;
    end else begin
      if (push) begin
        q[wptr]     <= '{dr: dr_in, cc: set_cc, data: wdata};
        q_vld[wptr] <= 1'b1;
        wptr        <= wptr + 1'b1;
      end
      if (pop) begin
        q_vld[rptr] <= 1'b0;
        rptr        <= rptr + 1'b1;
        wr          <= 1'b1;
        dr          <= q[rptr].dr;
        din         <= q[rptr].data;
        if (q[rptr].cc) psr <= nzp(q[rptr].data);
      end else begin
        wr <= 1'b0;
      end
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  for (genvar g = 0; g < DEPTH; g++) begin : g_match
    lc3_wb_match u_match (
      .vld (q_vld[g]),
      .dr  (q[g].dr),
      .sr1 (sr1),
      .sr2 (sr2),
      .m1  (m1[g]),
      .m2  (m2[g])
    );
  end

  assign hazard1 = |m1;
  assign hazard2 = |m2;

`ifdef LC3_WB_BYPASS_EN
  // Walk oldest to youngest; the last match assigned is the youngest.
  always_comb begin
    logic [AW-1:0] idx;
    idx       = '0;
    fwd1_data = '0;
    fwd2_data = '0;
    for (int i = 0; i < DEPTH; i++) begin
      idx = rptr + AW'(i);
      if (m1[idx]) fwd1_data = q[idx].data;
      if (m2[idx]) fwd2_data = q[idx].data;
    end
  end

  assign fwd1_valid = hazard1;
  assign fwd2_valid = hazard2;
`endif

endmodule

// File: tb/tb_lc3_writeback.sv
module tb_lc3_writeback;
  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        wb_valid = 1'b0;
  logic        wb_ready;
  logic [1:0]  W_Control = 2'd0;
  logic [15:0] aluout = '0, memout = '0, pcout = '0, npc = '0;
  logic [2:0]  dr_in = '0;
  logic        set_cc = 1'b0;
  logic        hold = 1'b0;
  logic [2:0]  sr1 = '0, sr2 = '0;
  logic        wr;
  logic [2:0]  dr;
  logic [15:0] din;
  logic [2:0]  psr;
  logic        hazard1, hazard2;
  logic [1:0]  count;
`ifdef LC3_WB_BYPASS_EN
  logic        fwd1_valid, fwd2_valid;
  logic [15:0] fwd1_data, fwd2_data;
`endif

  int errors = 0;
  int checks = 0;

  lc3_writeback #(.DEPTH(2), .DATA_W(16)) dut (
    .clock(clock), .reset(reset), .wb_valid(wb_valid), .wb_ready(wb_ready),
    .W_Control(W_Control), .aluout(aluout), .memout(memout), .pcout(pcout),
    .npc(npc), .dr_in(dr_in), .set_cc(set_cc), .hold(hold), .sr1(sr1),
    .sr2(sr2), .wr(wr), .dr(dr), .din(din), .psr(psr), .hazard1(hazard1),
    .hazard2(hazard2),
`ifdef LC3_WB_BYPASS_EN
    .fwd1_valid(fwd1_valid), .fwd1_data(fwd1_data),
    .fwd2_valid(fwd2_valid), .fwd2_data(fwd2_data),
`endif
    .count(count)
  );

  always #5 clock = ~clock;

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

  // Advance one edge and settle away from it.
  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    step(); step();
    reset = 1'b0;
    step();
    checks++; if (psr !== 3'b010) begin errors++; $display("FAIL reset_psr: got %b exp 010", psr); end
    checks++; if (wr !== 1'b0) begin errors++; $display("FAIL reset_wr: got %b exp 0", wr); end
    checks++; if (wb_ready !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b exp 1", wb_ready); end
    checks++; if (count !== 2'd0) begin errors++; $display("FAIL reset_count: got %0d exp 0", count); end
    checks++; if ({hazard1, hazard2} !== 2'b00) begin errors++; $display("FAIL reset_hazard: got %b exp 00", {hazard1, hazard2}); end
  endtask

  task automatic test_alu_mem();
    wb_valid = 1'b1; W_Control = 2'd0; aluout = 16'h8001; dr_in = 3'd3; set_cc = 1'b1; sr1 = 3'd3;
    step();
    wb_valid = 1'b0;
    checks++; if (count !== 2'd1) begin errors++; $display("FAIL alu_count: got %0d exp 1", count); end
    checks++; if (wr !== 1'b0) begin errors++; $display("FAIL alu_latency_wr: got %b exp 0", wr); end
    checks++; if (hazard1 !== 1'b1) begin errors++; $display("FAIL alu_hazard_enq: got %b exp 1", hazard1); end
    step();
    checks++; if ({wr, dr, din} !== {1'b1, 3'd3, 16'h8001}) begin errors++; $display("FAIL alu_write: got wr=%b dr=%0d din=%h exp 1/3/8001", wr, dr, din); end
    checks++; if (psr !== 3'b100) begin errors++; $display("FAIL alu_psr: got %b exp 100", psr); end
    checks++; if (hazard1 !== 1'b0) begin errors++; $display("FAIL alu_hazard_clr: got %b exp 0", hazard1); end
    wb_valid = 1'b1; W_Control = 2'd1; memout = 16'h0000; dr_in = 3'd5;
    step();
    wb_valid = 1'b0; memout = 16'hFFFF; // must not affect the stored entry
    step();
    checks++; if ({wr, dr, din} !== {1'b1, 3'd5, 16'h0000}) begin errors++; $display("FAIL mem_write: got wr=%b dr=%0d din=%h exp 1/5/0000", wr, dr, din); end
    checks++; if (psr !== 3'b010) begin errors++; $display("FAIL mem_psr: got %b exp 010", psr); end
    step();
    checks++; if ({wr, din} !== {1'b0, 16'h0000}) begin errors++; $display("FAIL idle_hold_din: got wr=%b din=%h exp 0/0000", wr, din); end
  endtask

  task automatic test_hold_full();
    hold = 1'b1; wb_valid = 1'b1; W_Control = 2'd0; set_cc = 1'b0;
    aluout = 16'h0111; dr_in = 3'd1;
    step();
    aluout = 16'h0222; dr_in = 3'd2;
    step();
    aluout = 16'h0666; dr_in = 3'd6; sr1 = 3'd1; // offered while full
    #1;
    checks++; if (wb_ready !== 1'b0) begin errors++; $display("FAIL full_ready: got %b exp 0", wb_ready); end
    checks++; if (count !== 2'd2) begin errors++; $display("FAIL full_count: got %0d exp 2", count); end
    checks++; if (hazard1 !== 1'b1) begin errors++; $display("FAIL full_hazard1: got %b exp 1", hazard1); end
    step();
    sr1 = 3'd6;
    #1;
    checks++; if ({wr, count} !== {1'b0, 2'd2}) begin errors++; $display("FAIL hold_nowrite: got wr=%b count=%0d exp 0/2", wr, count); end
    checks++; if (hazard1 !== 1'b0) begin errors++; $display("FAIL full_ignored: got hazard=%b exp 0", hazard1); end
    wb_valid = 1'b0; hold = 1'b0; sr1 = 3'd1;
    step();
    checks++; if ({wr, dr, din} !== {1'b1, 3'd1, 16'h0111}) begin errors++; $display("FAIL drain_r1: got wr=%b dr=%0d din=%h exp 1/1/0111", wr, dr, din); end
    checks++; if ({hazard1, count} !== {1'b0, 2'd1}) begin errors++; $display("FAIL drain_r1_state: got hz=%b count=%0d exp 0/1", hazard1, count); end
    step();
    checks++; if ({wr, dr, din, count} !== {1'b1, 3'd2, 16'h0222, 2'd0}) begin errors++; $display("FAIL drain_r2: got wr=%b dr=%0d din=%h count=%0d exp 1/2/0222/0", wr, dr, din, count); end
    step();
    checks++; if (wr !== 1'b0) begin errors++; $display("FAIL drain_empty_wr: got %b exp 0", wr); end
  endtask

  task automatic test_npc_pc();
    wb_valid = 1'b1; W_Control = 2'd0; aluout = 16'h0005; dr_in = 3'd0; set_cc = 1'b1;
    step(); wb_valid = 1'b0; step();
    checks++; if (psr !== 3'b001) begin errors++; $display("FAIL pos_psr: got %b exp 001", psr); end
    wb_valid = 1'b1; W_Control = 2'd3; npc = 16'h3005; dr_in = 3'd7; set_cc = 1'b0;
    step(); wb_valid = 1'b0; step();
    checks++; if ({wr, dr, din} !== {1'b1, 3'd7, 16'h3005}) begin errors++; $display("FAIL npc_write: got wr=%b dr=%0d din=%h exp 1/7/3005", wr, dr, din); end
    checks++; if (psr !== 3'b001) begin errors++; $display("FAIL npc_psr_keep: got %b exp 001", psr); end
    wb_valid = 1'b1; W_Control = 2'd2; pcout = 16'hC000; dr_in = 3'd6; set_cc = 1'b1;
    step(); wb_valid = 1'b0; step();
    checks++; if ({dr, din, psr} !== {3'd6, 16'hC000, 3'b100}) begin errors++; $display("FAIL pc_write: got dr=%0d din=%h psr=%b exp 6/c000/100", dr, din, psr); end
  endtask

  task automatic test_back_to_back();
    hold = 1'b1; wb_valid = 1'b1; W_Control = 2'd0; set_cc = 1'b0; sr1 = 3'd0; sr2 = 3'd4;
    aluout = 16'h0010; dr_in = 3'd4;
    step();
    aluout = 16'h0020;
    step();
    wb_valid = 1'b0;
    #1;
    checks++; if ({hazard1, hazard2} !== 2'b01) begin errors++; $display("FAIL b2b_hazard: got %b exp 01", {hazard1, hazard2}); end
`ifdef LC3_WB_BYPASS_EN
    checks++; if ({fwd2_valid, fwd2_data} !== {1'b1, 16'h0020}) begin errors++; $display("FAIL b2b_fwd2: got v=%b d=%h exp 1/0020", fwd2_valid, fwd2_data); end
    checks++; if ({fwd1_valid, fwd1_data} !== {1'b0, 16'h0000}) begin errors++; $display("FAIL b2b_fwd1: got v=%b d=%h exp 0/0000", fwd1_valid, fwd1_data); end
`endif
    hold = 1'b0;
    step();
    checks++; if ({wr, dr, din, hazard2} !== {1'b1, 3'd4, 16'h0010, 1'b1}) begin errors++; $display("FAIL b2b_first: got wr=%b dr=%0d din=%h hz=%b exp 1/4/0010/1", wr, dr, din, hazard2); end
`ifdef LC3_WB_BYPASS_EN
    checks++; if (fwd2_data !== 16'h0020) begin errors++; $display("FAIL b2b_fwd2_mid: got %h exp 0020", fwd2_data); end
`endif
    step();
    checks++; if ({din, hazard2} !== {16'h0020, 1'b0}) begin errors++; $display("FAIL b2b_second: got din=%h hz=%b exp 0020/0", din, hazard2); end
`ifdef LC3_WB_BYPASS_EN
    checks++; if (fwd2_data !== 16'h0000) begin errors++; $display("FAIL b2b_fwd2_clr: got %h exp 0000", fwd2_data); end
`endif
    // streaming: simultaneous enqueue/drain, no fall-through
    wb_valid = 1'b1; aluout = 16'h0A0A; dr_in = 3'd2;
    step();
    checks++; if ({wr, count} !== {1'b0, 2'd1}) begin errors++; $display("FAIL stream_nofall: got wr=%b count=%0d exp 0/1", wr, count); end
    aluout = 16'h0B0B; dr_in = 3'd3;
    step();
    wb_valid = 1'b0;
    checks++; if ({wr, din, count} !== {1'b1, 16'h0A0A, 2'd1}) begin errors++; $display("FAIL stream_both: got wr=%b din=%h count=%0d exp 1/0a0a/1", wr, din, count); end
    step();
    checks++; if ({wr, dr, din, count} !== {1'b1, 3'd3, 16'h0B0B, 2'd0}) begin errors++; $display("FAIL stream_last: got wr=%b dr=%0d din=%h count=%0d exp 1/3/0b0b/0", wr, dr, din, count); end
  endtask

  task automatic test_reset_mid();
    hold = 1'b1; wb_valid = 1'b1; W_Control = 2'd0; set_cc = 1'b1; sr1 = 3'd1;
    aluout = 16'h1111; dr_in = 3'd1;
    step();
    aluout = 16'h2222; dr_in = 3'd2;
    step();
    wb_valid = 1'b0;
    checks++; if ({count, psr} !== {2'd2, 3'b100}) begin errors++; $display("FAIL rmid_pre: got count=%0d psr=%b exp 2/100", count, psr); end
    reset = 1'b1; hold = 1'b0;
    step();
    checks++; if ({wr, count, psr, wb_ready, hazard1} !== {1'b0, 2'd0, 3'b010, 1'b1, 1'b0}) begin errors++; $display("FAIL rmid_state: got wr=%b count=%0d psr=%b rdy=%b hz=%b exp 0/0/010/1/0", wr, count, psr, wb_ready, hazard1); end
    reset = 1'b0;
    step();
    checks++; if ({wr, count} !== {1'b0, 2'd0}) begin errors++; $display("FAIL rmid_after: got wr=%b count=%0d exp 0/0", wr, count); end
  endtask

  initial begin
    test_reset();
    test_alu_mem();
    test_hold_full();
    test_npc_pc();
    test_back_to_back();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
